if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC and fetches from instruction memory over a req/ready handshake.
//  Fills the IF/ID register and takes branch/jump redirects resolved in ID (branch compare result plus target).
//  Honours hazard-unit stalls. Discards or delivers the in-flight fetch on a redirect.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value after reset
//  NOP_INSTR  32'h0000_0000  word loaded into ifid_instr for bubbles
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  stall        in   1   hazard unit: hold IF/ID and PC this cycle
//  id_redirect  in   1   ID resolved taken branch or jump; valid only when stall=0
//  id_target    in   32  redirect PC; word aligned
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address; stable while imem_req=1 and imem_ready=0
//  imem_ready   in   1   imem_rdata valid; completes the outstanding request
//  imem_rdata   in   32  fetched instruction
//  ifid_instr   out  32  IF/ID instruction
//  ifid_pc4     out  32  IF/ID PC+4 of that instruction
//  ifid_valid   out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, req_addr=RESET_PC, state=FETCH
//   - ifid_instr=NOP_INSTR, ifid_pc4=RESET_PC, ifid_valid=0, hold buffer empty
//  Outputs: imem_req=1 in FETCH and DRAIN, 0 in HOLD. imem_addr=req_addr, latched when a new request issues.
//  At most one request outstanding. Fetch latency is whatever imem_ready gives; min 1 cycle, so back-to-back fetches give 1 instr/cycle.
//  FETCH:
//   - ready & !stall & !redirect: ifid<={rdata,req_addr+4,1}; pc=req_addr=req_addr+4
//   - ready & stall: rdata goes to hold buffer, IF/ID unchanged -> HOLD
//   - !ready & !stall & !redirect: ifid_valid<=0 (bubble), instr<=NOP_INSTR
//   - stall (any ready): IF/ID and pc unchanged
//  HOLD (stall persists): IF/ID frozen, no request.
//   - stall drops: buffer -> IF/ID (valid=1), pc=req_addr=pc+4 -> FETCH
//   - redirect is never seen in HOLD, because ID is stalled
//  Redirect (id_redirect=1, stall=0) always sets pc<=id_target. Handling of the in-flight fetch:
//   - ready same cycle: response handled per CONFIGURATION; req_addr<=id_target; stay FETCH
//   - !ready: keep req_addr (request must stay stable) -> DRAIN
//  DRAIN: on ready, response handled per CONFIGURATION, req_addr<=pc -> FETCH.
//   - stall in DRAIN with ready and delay slot delivered: go to HOLD with the buffer
//   - second redirect in DRAIN (DS only): pc overwritten, last one wins
//  Bubbles: IF/ID is a bubble on every non-stall cycle that delivers no instruction.
//  Arithmetic: +4 is mod 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
//  Mid-operation reset: outstanding request abandoned. A stale imem_ready after reset is ignored only if it arrives while rst_n=0.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined:
//   - the instruction fetched at branch PC+4 is the delay slot
//   - it is delivered to IF/ID with valid=1, including when it completes in DRAIN
//  BRANCH_DELAY_SLOT_EN undefined:
//   - that response is discarded: IF/ID gets a bubble (valid=0, NOP_INSTR)
//   - redirect costs 1 bubble, or more while DRAIN waits for ready
// TESTING
//  1 Reset, then ready held 1, no stall -> imem_addr 3000,3004,3008; ifid_pc4 3004,3008,300C; valid=1 from 2nd edge.
//  2 ready every 3rd cycle -> two bubbles (valid=0, instr=0) between valid words; imem_addr stable while waiting.
//  3 stall=1 for 2 cycles with ready=1 -> IF/ID frozen, imem_req=0 in HOLD; buffered word delivered on release, none lost or duplicated.
//  4 Redirect to 32'h0000_3100 with ready=1, DS_EN undefined -> next IF/ID bubble, following imem_addr=3100; DS_EN defined -> word at branch PC+4 delivered valid.
//  5 Redirect while !ready (2 more cycles) -> imem_addr holds old address, response discarded or delivered per macro, then imem_addr=3100.
//  6 rst_n pulled low during DRAIN -> all outputs at reset values immediately; fetch restarts at 3000.

Source files
------------

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC and fetches over a req/ready handshake into IF/ID.
// Define BRANCH_DELAY_SLOT_EN to deliver the delay-slot word after a redirect instead of squashing it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] hold_buf;
  logic [31:0] hold_pc4;
  logic [31:0] hold_next;
  logic        hold_cap;

  function automatic logic [31:0] inc4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign imem_addr = req_addr;

  // A stalled response is parked here; from DRAIN the next fetch resumes at the redirect PC.
  assign hold_cap = stall && imem_ready &&
                    ((state == FETCH) || ((state == DRAIN) && DS_EN));

  always_ff @(posedge clk) begin
    if (hold_cap) begin
      hold_buf  <= imem_rdata;
      hold_pc4  <= inc4(req_addr);
      hold_next <= (state == FETCH) ? inc4(req_addr) : pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      imem_req   <= 1'b1;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= RESET_PC;
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (stall) begin
            if (imem_ready) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else if (id_redirect) begin
            pc <= id_target;
            if (imem_ready) begin
              ifid_instr <= DS_EN ? imem_rdata : NOP_INSTR;
              ifid_valid <= DS_EN;
              if (DS_EN) ifid_pc4 <= inc4(req_addr);
              req_addr   <= id_target;
            end else begin
              ifid_instr <= NOP_INSTR;
              ifid_valid <= 1'b0;
              state      <= DRAIN;
            end
          end else if (imem_ready) begin
            ifid_instr <= imem_rdata;
            ifid_pc4   <= inc4(req_addr);
            ifid_valid <= 1'b1;
            pc         <= inc4(req_addr);
            req_addr   <= inc4(req_addr);
          end else begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_instr <= hold_buf;
            ifid_pc4   <= hold_pc4;
            ifid_valid <= 1'b1;
            pc         <= hold_next;
            req_addr   <= hold_next;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end
        end
        DRAIN: begin
          // The old request must finish at its original address before the redirect target issues.
          if (stall) begin
            if (imem_ready) begin
              if (DS_EN) begin
                state    <= HOLD;
                imem_req <= 1'b0;
              end else begin
                req_addr <= pc;
                state    <= FETCH;
              end
            end
          end else begin
            if (id_redirect) pc <= id_target;
            if (imem_ready) begin
              ifid_instr <= DS_EN ? imem_rdata : NOP_INSTR;
              ifid_valid <= DS_EN;
              if (DS_EN) ifid_pc4 <= inc4(req_addr);
              req_addr   <= id_redirect ? id_target : pc;
              state      <= FETCH;
            end else begin
              ifid_instr <= NOP_INSTR;
              ifid_valid <= 1'b0;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns {16'hC0DE, addr[15:0]} for every fetch.
module tb_if_fetch_stage;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  int passes = 0;
  int total  = 0;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .id_redirect(id_redirect), .id_target(id_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid, input logic [31:0] addr, input logic req);
    chk({tag, ".instr"}, ifid_instr, instr);
    chk({tag, ".pc4"},   ifid_pc4,   pc4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    chk({tag, ".addr"},  imem_addr,  addr);
    chk({tag, ".req"},   {31'd0, imem_req},   {31'd0, req});
  endtask

  task automatic cyc(input logic rdy, input logic stl, input logic redir, input logic [31:0] tgt);
    imem_ready  = rdy;
    stall       = stl;
    id_redirect = redir;
    id_target   = tgt;
    imem_rdata  = {16'hC0DE, imem_addr[15:0]};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; id_redirect = 1'b0; id_target = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h3000, 1'b0, 32'h3000, 1'b1);
    rst_n = 1'b1;

    // back-to-back fetches
    cyc(1, 0, 0, 0); chk_all("seq0", 32'hC0DE3000, 32'h3004, 1, 32'h3004, 1);
    cyc(1, 0, 0, 0); chk_all("seq1", 32'hC0DE3004, 32'h3008, 1, 32'h3008, 1);
    cyc(1, 0, 0, 0); chk_all("seq2", 32'hC0DE3008, 32'h300C, 1, 32'h300C, 1);

    // slow memory: ready every third cycle
    cyc(0, 0, 0, 0); chk_all("slow0", 32'h0, 32'h300C, 0, 32'h300C, 1);
    cyc(0, 0, 0, 0); chk_all("slow1", 32'h0, 32'h300C, 0, 32'h300C, 1);
    cyc(1, 0, 0, 0); chk_all("slow2", 32'hC0DE300C, 32'h3010, 1, 32'h3010, 1);

    // stall with a completed fetch goes to HOLD
    cyc(1, 1, 0, 0); chk_all("hold0", 32'hC0DE300C, 32'h3010, 1, 32'h3010, 0);
    cyc(0, 1, 0, 0); chk_all("hold1", 32'hC0DE300C, 32'h3010, 1, 32'h3010, 0);
    cyc(0, 0, 0, 0); chk_all("rel",   32'hC0DE3010, 32'h3014, 1, 32'h3014, 1);
    cyc(1, 0, 0, 0); chk_all("rel1",  32'hC0DE3014, 32'h3018, 1, 32'h3018, 1);

    // redirect with the in-flight fetch completing the same cycle
    cyc(1, 0, 1, 32'h3100);
    if (DS) chk_all("redir", 32'hC0DE3018, 32'h301C, 1, 32'h3100, 1);
    else    chk_all("redir", 32'h0,        32'h3018, 0, 32'h3100, 1);
    cyc(1, 0, 0, 0); chk_all("redir1", 32'hC0DE3100, 32'h3104, 1, 32'h3104, 1);

    // redirect while the fetch is still outstanding
    cyc(0, 0, 1, 32'h3100); chk_all("drain0", 32'h0, 32'h3104, 0, 32'h3104, 1);
    cyc(0, 0, 0, 0);        chk_all("drain1", 32'h0, 32'h3104, 0, 32'h3104, 1);
    cyc(1, 0, 0, 0);
    if (DS) chk_all("drain2", 32'hC0DE3104, 32'h3108, 1, 32'h3100, 1);
    else    chk_all("drain2", 32'h0,        32'h3104, 0, 32'h3100, 1);
    cyc(1, 0, 0, 0); chk_all("drain3", 32'hC0DE3100, 32'h3104, 1, 32'h3104, 1);

    // asynchronous reset while in DRAIN
    cyc(0, 0, 1, 32'h3100); chk_all("drain4", 32'h0, 32'h3104, 0, 32'h3104, 1);
    imem_ready = 1'b1; id_redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("arst", 32'h0, 32'h3000, 0, 32'h3000, 1);
    @(posedge clk);
    #1 chk_all("arst1", 32'h0, 32'h3000, 0, 32'h3000, 1);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0); chk_all("restart", 32'hC0DE3000, 32'h3004, 1, 32'h3004, 1);

    // PC+4 wraps silently to zero
    cyc(1, 0, 1, 32'hFFFF_FFFC);
    if (DS) chk_all("wrap0", 32'hC0DE3004, 32'h3008, 1, 32'hFFFF_FFFC, 1);
    else    chk_all("wrap0", 32'h0,        32'h3004, 0, 32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 0); chk_all("wrap1", 32'hC0DEFFFC, 32'h0, 1, 32'h0, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
